// File: rtl/umi_ep_arbiter_pkg.sv
// Shared UMI opcode constants and the command decode used by the endpoint arbiter.
package umi_ep_arbiter_pkg;

  // Opcode position inside a UMI packet, matching the umi_unpack field layout.
  localparam int UMI_OPCODE_LSB = 0;
  localparam int UMI_OPCODE_W   = 5;

  typedef logic [UMI_OPCODE_W-1:0] umi_opcode_t;

  localparam umi_opcode_t UMI_REQ_READ  = 5'h01;
  localparam umi_opcode_t UMI_REQ_WRITE = 5'h03;

  function automatic logic umi_is_read(input umi_opcode_t opcode);
    return opcode == UMI_REQ_READ;
  endfunction

endpackage

// File: rtl/umi_id_fifo.sv
// In-order FIFO of requester IDs, one entry per outstanding read.
module umi_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Power-of-2 depth lets the pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/umi_ep_arbiter.sv
// Round-robin sharing of one UMI endpoint among N requesters, with in-order
// read-response routing back to the requester that issued each read.
module umi_ep_arbiter
  import umi_ep_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int UW    = 256,
  parameter int AW    = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    req_in_valid,
  input  logic [N*UW-1:0] req_in_packet,
  output logic [N-1:0]    req_in_ready,
  output logic            req_out_valid,
  output logic [UW-1:0]   req_out_packet,
  input  logic            req_out_ready,
  input  logic            rsp_in_valid,
  input  logic [UW-1:0]   rsp_in_packet,
  output logic            rsp_in_ready,
  output logic [N-1:0]    rsp_out_valid,
  output logic [UW-1:0]   rsp_out_packet,
  input  logic [N-1:0]    rsp_out_ready,
  output logic            err_orphan
);

  localparam int IW = $clog2(N);

  // The packet must hold the command word plus source and destination addresses.
  if (UW < 32 + 2 * AW) begin : g_bad_width
    $error("umi_ep_arbiter: UW too small for AW");
  end

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both high; a held valid keeps its packet stable until it is accepted.

  // Returns {found, index} of the first candidate at or after ptr, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] cand, input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (cand[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  logic [N-1:0]  is_read, blocked, cand;
  logic          fifo_full, fifo_empty;
  logic [IW-1:0] fifo_head;
  logic [IW:0]   pick;
  logic [IW-1:0] winner;
  logic          load, grant, push, pop;

  logic          req_out_valid_q, req_out_valid_d;
  logic [UW-1:0] req_out_packet_q, req_out_packet_d;
  logic [IW-1:0] rr_q, rr_d;
  logic          err_orphan_q, err_orphan_d;

  always_comb begin
    is_read = '0;
    for (int i = 0; i < N; i++) begin
      is_read[i] = umi_is_read(req_in_packet[i*UW + UMI_OPCODE_LSB +: UMI_OPCODE_W]);
    end
  end

  always_comb begin
    load    = !req_out_valid_q | req_out_ready;
    // Only reads consume an ID slot, so only reads stall on a full FIFO.
    blocked = is_read & {N{fifo_full}};
    cand    = req_in_valid & ~blocked;
    pick    = rr_pick(cand, rr_q);
    winner  = pick[IW-1:0];
    grant   = pick[IW] & load;

    req_in_ready = '0;
    if (grant) req_in_ready[winner] = 1'b1;

    req_out_valid_d  = req_out_valid_q;
    req_out_packet_d = req_out_packet_q;
    rr_d             = rr_q;
    if (grant) begin
      req_out_valid_d  = 1'b1;
      req_out_packet_d = req_in_packet[winner*UW +: UW];
      rr_d             = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
    end else if (req_out_ready) begin
      req_out_valid_d = 1'b0;
    end
    push = grant & is_read[winner];

    rsp_out_valid = '0;
    if (rsp_in_valid && !fifo_empty) rsp_out_valid[fifo_head] = 1'b1;
    rsp_in_ready = !fifo_empty & rsp_out_ready[fifo_head];
    pop          = rsp_in_valid & rsp_in_ready;
    // A response with nothing outstanding is left unaccepted and flagged.
    err_orphan_d = err_orphan_q | (rsp_in_valid & fifo_empty);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      req_out_valid_q <= 1'b0;
      rr_q            <= '0;
      err_orphan_q    <= 1'b0;
    end else begin
      req_out_valid_q <= req_out_valid_d;
      rr_q            <= rr_d;
      err_orphan_q    <= err_orphan_d;
    end
  end

  always_ff @(posedge clk) begin
    req_out_packet_q <= req_out_packet_d;
  end

  umi_id_fifo #(
    .W    (IW),
    .DEPTH(DEPTH)
  ) u_id_fifo (
    .clk      (clk),
    .nreset   (nreset),
    .push     (push),
    .push_data(winner),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign req_out_valid  = req_out_valid_q;
  assign req_out_packet = req_out_packet_q;
  assign rsp_out_packet = rsp_in_packet;
  assign err_orphan     = err_orphan_q;

endmodule

// File: tb/tb_umi_ep_arbiter.sv
// Directed bench for umi_ep_arbiter: fairness, backpressure, routing, full FIFO, orphan, reset.
module tb_umi_ep_arbiter;
  import umi_ep_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int UW    = 256;
  localparam int AW    = 64;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            nreset;
  logic [N-1:0]    req_in_valid;
  logic [N*UW-1:0] req_in_packet;
  logic [N-1:0]    req_in_ready;
  logic            req_out_valid;
  logic [UW-1:0]   req_out_packet;
  logic            req_out_ready;
  logic            rsp_in_valid;
  logic [UW-1:0]   rsp_in_packet;
  logic            rsp_in_ready;
  logic [N-1:0]    rsp_out_valid;
  logic [UW-1:0]   rsp_out_packet;
  logic [N-1:0]    rsp_out_ready;
  logic            err_orphan;

  logic [UW-1:0]   req_pkt [N];
  logic [UW-1:0]   exp_q [$];
  logic [N+UW-1:0] exp_rsp_q [$];
  logic [UW-1:0]   mon_req;
  logic [N+UW-1:0] mon_rsp;
  int              total = 0;
  int              bad   = 0;

  umi_ep_arbiter #(
    .N(N), .UW(UW), .AW(AW), .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .req_in_valid  (req_in_valid),
    .req_in_packet (req_in_packet),
    .req_in_ready  (req_in_ready),
    .req_out_valid (req_out_valid),
    .req_out_packet(req_out_packet),
    .req_out_ready (req_out_ready),
    .rsp_in_valid  (rsp_in_valid),
    .rsp_in_packet (rsp_in_packet),
    .rsp_in_ready  (rsp_in_ready),
    .rsp_out_valid (rsp_out_valid),
    .rsp_out_packet(rsp_out_packet),
    .rsp_out_ready (rsp_out_ready),
    .err_orphan    (err_orphan)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always_comb begin
    req_in_packet = '0;
    for (int i = 0; i < N; i++) req_in_packet[i*UW +: UW] = req_pkt[i];
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [N+UW-1:0] act, input logic [N+UW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [UW-1:0] mk_pkt(input umi_opcode_t op, input logic [31:0] tag);
    logic [UW-1:0] p;
    p = '0;
    p[UMI_OPCODE_LSB +: UMI_OPCODE_W] = op;
    p[63:32]   = tag;
    p[255:224] = ~tag;
    return p;
  endfunction

  function automatic logic [UW-1:0] rsp_pkt(input logic [31:0] tag);
    return {8{32'hC0DE_0000 | tag}};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ready(input string name, input logic [N-1:0] exp);
    @(negedge clk);
    check(name, N'(req_in_ready), N'(exp));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (nreset) begin
      if (req_out_valid && req_out_ready) begin
        if (exp_q.size() == 0) begin
          check("req_out_unexpected", 1, 0);
        end else begin
          mon_req = exp_q.pop_front();
          check("req_out_packet", req_out_packet, mon_req);
        end
      end
      if ((rsp_out_valid & rsp_out_ready) != '0) begin
        if (exp_rsp_q.size() == 0) begin
          check("rsp_out_unexpected", 1, 0);
        end else begin
          mon_rsp = exp_rsp_q.pop_front();
          check("rsp_out_route_packet", {rsp_out_valid, rsp_out_packet}, mon_rsp);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [N-1:0] oh;
    nreset        = 1'b0;
    req_in_valid  = '0;
    req_out_ready = 1'b0;
    rsp_in_valid  = 1'b0;
    rsp_in_packet = '0;
    rsp_out_ready = '0;
    for (int i = 0; i < N; i++) req_pkt[i] = '0;
    cyc();
    cyc();
    @(negedge clk);
    check("reset_req_out_valid", req_out_valid, 0);
    check("reset_err_orphan", err_orphan, 0);
    check("reset_rsp_out_valid", rsp_out_valid, 0);
    nreset = 1'b1;
    cyc();

    // Fairness: everyone writes continuously -> 0,1,2,3,0.
    req_out_ready = 1'b1;
    rsp_out_ready = '1;
    for (int i = 0; i < N; i++) req_pkt[i] = mk_pkt(UMI_REQ_WRITE, 32'h100 + i);
    req_in_valid = '1;
    for (int k = 0; k < 5; k++) begin
      oh = N'(1) << (k % N);
      exp_q.push_back(req_pkt[k % N]);
      expect_ready("fair_grant", oh);
      cyc();
    end
    req_in_valid = '0;
    cyc();
    @(negedge clk);
    check("idle_valid_drop", req_out_valid, 0);
    cyc();

    // Backpressure: pointer sits at 1; hold 5 cycles, then resume with 2.
    req_out_ready = 1'b0;
    for (int i = 0; i < N; i++) req_pkt[i] = mk_pkt(UMI_REQ_WRITE, 32'h200 + i);
    req_in_valid = '1;
    exp_q.push_back(req_pkt[1]);
    expect_ready("bp_first_grant", 4'b0010);
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_no_ready", req_in_ready, 0);
      check("bp_valid_held", req_out_valid, 1);
      check("bp_packet_stable", req_out_packet, req_pkt[1]);
      cyc();
    end
    req_out_ready = 1'b1;
    exp_q.push_back(req_pkt[2]);
    expect_ready("bp_resume_next", 4'b0100);
    cyc();
    req_in_valid = '0;
    cyc();
    cyc();

    // Routing: read from 2 then read from 0.
    req_pkt[2] = mk_pkt(UMI_REQ_READ, 32'h300);
    req_in_valid = 4'b0100;
    exp_q.push_back(req_pkt[2]);
    exp_rsp_q.push_back({4'b0100, rsp_pkt(32'h300)});
    expect_ready("route_grant_2", 4'b0100);
    cyc();
    req_pkt[0] = mk_pkt(UMI_REQ_READ, 32'h301);
    req_in_valid = 4'b0001;
    exp_q.push_back(req_pkt[0]);
    exp_rsp_q.push_back({4'b0001, rsp_pkt(32'h301)});
    expect_ready("route_grant_0", 4'b0001);
    cyc();
    req_in_valid = '0;
    cyc();
    rsp_in_valid  = 1'b1;
    rsp_in_packet = rsp_pkt(32'h300);
    @(negedge clk);
    check("route_rsp_in_ready", rsp_in_ready, 1);
    cyc();
    rsp_in_packet = rsp_pkt(32'h301);
    cyc();
    rsp_in_valid = 1'b0;
    cyc();

    // Full: four reads outstanding from requester 1.
    for (int k = 0; k < DEPTH; k++) begin
      req_pkt[1] = mk_pkt(UMI_REQ_READ, 32'h400 + k);
      req_in_valid = 4'b0010;
      exp_q.push_back(req_pkt[1]);
      exp_rsp_q.push_back({4'b0010, rsp_pkt(32'h400 + k)});
      expect_ready("full_fill_grant", 4'b0010);
      cyc();
    end
    req_pkt[1] = mk_pkt(UMI_REQ_READ, 32'h404);
    req_pkt[3] = mk_pkt(UMI_REQ_WRITE, 32'h405);
    req_in_valid = 4'b1010;
    exp_q.push_back(req_pkt[3]);
    expect_ready("full_write_passes", 4'b1000);
    cyc();
    req_in_valid = 4'b0010;
    expect_ready("full_read_blocked", 4'b0000);
    cyc();
    rsp_in_valid  = 1'b1;
    rsp_in_packet = rsp_pkt(32'h400);
    expect_ready("full_blocked_during_pop", 4'b0000);
    cyc();
    rsp_in_valid = 1'b0;
    exp_q.push_back(req_pkt[1]);
    exp_rsp_q.push_back({4'b0010, rsp_pkt(32'h404)});
    expect_ready("full_read_after_pop", 4'b0010);
    cyc();
    req_in_valid = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      rsp_in_valid  = 1'b1;
      rsp_in_packet = rsp_pkt(32'h400 + k);
      cyc();
    end
    rsp_in_valid = 1'b0;
    cyc();

    // Orphan: response with nothing outstanding.
    rsp_in_valid  = 1'b1;
    rsp_in_packet = rsp_pkt(32'h500);
    @(negedge clk);
    check("orphan_rsp_in_ready", rsp_in_ready, 0);
    check("orphan_rsp_out_valid", rsp_out_valid, 0);
    check("orphan_err_before", err_orphan, 0);
    cyc();
    @(negedge clk);
    check("orphan_err_set", err_orphan, 1);
    rsp_in_valid = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    check("orphan_err_sticky", err_orphan, 1);
    cyc();

    // Reset mid-traffic: a read is held in the stage and outstanding.
    req_out_ready = 1'b0;
    req_pkt[0] = mk_pkt(UMI_REQ_READ, 32'h600);
    req_in_valid = 4'b0001;
    cyc();
    req_in_valid = '0;
    @(negedge clk);
    check("pre_reset_outstanding", rsp_in_ready, 1);
    #1 nreset = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_req_out_valid", req_out_valid, 0);
    check("midreset_err_orphan", err_orphan, 0);
    check("midreset_rsp_in_ready", rsp_in_ready, 0);
    check("midreset_req_in_ready", req_in_ready, 0);
    nreset = 1'b1;
    cyc();
    cyc();

    check("req_queue_drained", exp_q.size(), 0);
    check("rsp_queue_drained", exp_rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
